// File: rtl/wdm_pkg.sv
// wdm_pkg: state/phase encodings and default timing constants for the ring lock controller
package wdm_pkg;
   localparam int DefDacWidth     = 8;
   localparam int DefStepSize     = 1;
   localparam int DefSettleCycles = 4;
   localparam int DefAvgLog2      = 2;
   localparam int DefDitherStep   = 2;
   typedef enum logic [2:0] {IDLE, SETTLE, MEAS, SWEEP, SEEK, LOCK, DITH_LO, DITH_HI} ring_lock_state_e;
   typedef enum logic [1:0] {PH_SWEEP, PH_LO, PH_HI, PH_C} dith_phase_e;
   typedef logic [DefDacWidth-1:0] tune_code_t;
endpackage

// File: rtl/ring_lock_avg.sv
// ring_lock_avg: averages 2**AvgLog2 consecutive samples; done pulses 2**AvgLog2 cycles after start
module ring_lock_avg #(
   parameter int AdcWidth = 10,
   parameter int AvgLog2  = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [AdcWidth-1:0] i_pwr,
   output logic                o_done,
   output logic [AdcWidth-1:0] o_avg
);
   localparam logic [AvgLog2:0] Num = (AvgLog2+1)'(1 << AvgLog2);
   logic [AdcWidth+AvgLog2-1:0] acc_q, acc_d;
   logic [AvgLog2:0]            cnt_q, cnt_d;
   logic                        run_q, done_q;
   assign acc_d  = (i_start ? '0 : acc_q) + (AdcWidth+AvgLog2)'(i_pwr);
   assign cnt_d  = i_start ? (AvgLog2+1)'(1) : cnt_q + 1'b1;
   assign o_done = done_q;
   assign o_avg  = AdcWidth'(acc_q >> AvgLog2);
   // accumulate from the start cycle on; a new start discards any measurement in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (i_start || run_q) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= cnt_d != Num;
            done_q <= cnt_d == Num;
         end
      end
   end
endmodule

// File: rtl/ring_lock_ctrl.sv
// ring_lock_ctrl: sweep/seek/hold wavelength lock for one microring; RING_LOCK_TRACK_EN adds lock-phase dither tracking
module ring_lock_ctrl
   import wdm_pkg::*;
#(
   parameter int  AdcWidth        = 10,
   parameter int  DacWidth        = DefDacWidth,
   parameter int  StepSize        = DefStepSize,
   parameter int  SettleCycles    = DefSettleCycles,
   parameter int  AvgLog2         = DefAvgLog2,
   parameter int  DitherStep      = DefDitherStep,
   parameter real TuningFullScale = 10.0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [AdcWidth-1:0] i_pwr_code,
   output logic [DacWidth-1:0] o_tune_code,
   output real                 o_real_tuning_dist,
   output logic                o_busy,
   output logic                o_locked,
   output logic [DacWidth-1:0] o_peak_code,
   output logic [AdcWidth-1:0] o_peak_pwr
);
   localparam int FullScale = 2**DacWidth - 1;
   ring_lock_state_e    state_q;
   logic [DacWidth-1:0] tune_q, peak_code_q;
   logic [AdcWidth-1:0] peak_pwr_q, avg;
   logic [15:0]         cnt_q;
   logic [DacWidth:0]   step_code;
   logic                busy_q, locked_q, avg_done, avg_start;
   assign step_code = {1'b0, tune_q} + (DacWidth+1)'(StepSize);
   assign avg_start = state_q == MEAS && cnt_q == '0;
   ring_lock_avg #(.AdcWidth(AdcWidth), .AvgLog2(AvgLog2)) u_avg (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_start(avg_start),
      .i_pwr  (i_pwr_code),
      .o_done (avg_done),
      .o_avg  (avg)
   );
`ifdef RING_LOCK_TRACK_EN
   dith_phase_e         phase_q;
   logic [DacWidth-1:0] center_q, lo_code, hi_code;
   logic [AdcWidth-1:0] lo_pwr_q, hi_pwr_q;
   logic                mv_up, mv_dn;
   assign lo_code = tune_q < DacWidth'(DitherStep) ? '0 : tune_q - DacWidth'(DitherStep);
   assign hi_code = {1'b0, center_q} + (DacWidth+1)'(DitherStep) > (DacWidth+1)'(FullScale) ?
                    DacWidth'(FullScale) : center_q + DacWidth'(DitherStep);
   assign mv_up = (hi_pwr_q > avg && lo_pwr_q > avg) || hi_pwr_q > lo_pwr_q;
   assign mv_dn = !mv_up && lo_pwr_q > hi_pwr_q;
`endif
   // lock sequencer: start (when idle/locked) clears results and sweeps, then parks on the best code
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         tune_q      <= '0;
         peak_code_q <= '0;
         peak_pwr_q  <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
`ifdef RING_LOCK_TRACK_EN
         phase_q     <= PH_SWEEP;
         center_q    <= '0;
         lo_pwr_q    <= '0;
         hi_pwr_q    <= '0;
`endif
      end else if (i_start && !busy_q) begin
         state_q     <= SETTLE;
         tune_q      <= '0;
         peak_code_q <= '0;
         peak_pwr_q  <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b1;
         locked_q    <= 1'b0;
`ifdef RING_LOCK_TRACK_EN
         phase_q     <= PH_SWEEP;
`endif
      end else begin
         case (state_q)
            SETTLE: begin
               cnt_q <= cnt_q == 16'(SettleCycles - 1) ? '0 : cnt_q + 1'b1;
               if (cnt_q == 16'(SettleCycles - 1)) state_q <= MEAS;
            end
            MEAS: begin
               cnt_q <= cnt_q == 16'((1 << AvgLog2) - 1) ? '0 : cnt_q + 1'b1;
`ifdef RING_LOCK_TRACK_EN
               if (cnt_q == 16'((1 << AvgLog2) - 1))
                  state_q <= phase_q == PH_LO ? DITH_LO : phase_q == PH_HI ? DITH_HI :
                             phase_q == PH_C ? LOCK : SWEEP;
`else
               if (cnt_q == 16'((1 << AvgLog2) - 1)) state_q <= SWEEP;
`endif
            end
            SWEEP: begin
               if (avg_done && avg > peak_pwr_q) begin
                  peak_pwr_q  <= avg;
                  peak_code_q <= tune_q;
               end
               if (step_code > (DacWidth+1)'(FullScale)) state_q <= SEEK;
               else begin
                  tune_q  <= step_code[DacWidth-1:0];
                  state_q <= SETTLE;
               end
            end
            SEEK: begin
               tune_q   <= peak_code_q;
               busy_q   <= 1'b0;
               locked_q <= 1'b1;
               state_q  <= LOCK;
            end
`ifdef RING_LOCK_TRACK_EN
            LOCK: begin
               if (avg_done) begin
                  if (mv_up && tune_q != DacWidth'(FullScale)) tune_q <= tune_q + 1'b1;
                  else if (mv_dn && tune_q != '0) tune_q <= tune_q - 1'b1;
               end else begin
                  center_q <= tune_q;
                  tune_q   <= lo_code;
                  phase_q  <= PH_LO;
                  state_q  <= SETTLE;
               end
            end
            DITH_LO: begin
               lo_pwr_q <= avg;
               tune_q   <= hi_code;
               phase_q  <= PH_HI;
               state_q  <= SETTLE;
            end
            DITH_HI: begin
               hi_pwr_q <= avg;
               tune_q   <= center_q;
               phase_q  <= PH_C;
               state_q  <= SETTLE;
            end
`else
            LOCK: state_q <= LOCK;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
   assign o_tune_code        = tune_q;
   assign o_busy             = busy_q;
   assign o_locked           = locked_q;
   assign o_peak_code        = peak_code_q;
   assign o_peak_pwr         = peak_pwr_q;
   assign o_real_tuning_dist = TuningFullScale * real'(tune_q) / real'(FullScale);
endmodule

// File: tb/tb_ring_lock_ctrl.sv
// tb_ring_lock_ctrl: table + scoreboard check of sweep/lock, plateau, step boundary, reset and tracking
module tb_ring_lock_ctrl;
   logic       clk = 1'b0, rst = 1'b0, start_a = 1'b0, start_b = 1'b0;
   logic [9:0] pwr_a, pwr_b, ppwr_a, ppwr_b;
   logic [7:0] tune_a, tune_b, pcode_a, pcode_b;
   logic       busy_a, busy_b, lock_a, lock_b;
   real        dist_a, dist_b;
   int         mode = 0, ctr = 100;
   int         n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   ring_lock_ctrl u_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_pwr_code(pwr_a),
      .o_tune_code(tune_a), .o_real_tuning_dist(dist_a), .o_busy(busy_a),
      .o_locked(lock_a), .o_peak_code(pcode_a), .o_peak_pwr(ppwr_a));

   ring_lock_ctrl #(.StepSize(3)) u_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_pwr_code(pwr_b),
      .o_tune_code(tune_b), .o_real_tuning_dist(dist_b), .o_busy(busy_b),
      .o_locked(lock_b), .o_peak_code(pcode_b), .o_peak_pwr(ppwr_b));

   function automatic logic [9:0] model(int code, int md, int c);
      int d;
      d = code > c ? code - c : c - code;
      if (md == 1) return (code >= 40 && code <= 45) ? 10'd700 : 10'd100;
      return d <= 3 ? 10'(900 - 100 * d) : 10'd100;
   endfunction

   always_comb pwr_a = model(int'(tune_a), mode, ctr);
   always_comb pwr_b = model(int'(tune_b), mode, ctr);

   typedef struct {
      int dut;
      int md;
      int c;
      int exp_code;
      int exp_pwr;
      int exp_lat;
   } vec_t;

   vec_t vecs[5];
   vec_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int dut);
      if (dut == 0) start_a = 1'b1; else start_b = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // waits for lock on the chosen DUT, tracking sweep monotonicity and maximum code while busy
   task automatic wait_lock(input int dut, output int lat, output int decr, output int mx);
      int prev;
      lat = 0; decr = 0; mx = 0; prev = 0;
      while (!(dut == 0 ? lock_a : lock_b) && lat < 5000) begin
         if (dut == 0 ? busy_a : busy_b) begin
            int t;
            t = dut == 0 ? int'(tune_a) : int'(tune_b);
            if (t < prev) decr++;
            if (t > mx) mx = t;
            prev = t;
         end
         tick();
         lat++;
      end
   endtask

   task automatic check_lock(input string tag, input int lat, input int decr, input int mx);
      vec_t e;
      e = exp_q.pop_front();
      if (e.dut == 0) begin
         chk({tag, "_locked"}, int'(lock_a), 1);
         chk({tag, "_busy"}, int'(busy_a), 0);
         chk({tag, "_peak_code"}, int'(pcode_a), e.exp_code);
         chk({tag, "_peak_pwr"}, int'(ppwr_a), e.exp_pwr);
         chk({tag, "_tune"}, int'(tune_a), e.exp_code);
         chk({tag, "_dist_ok"}, int'(dist_a > 10.0 * e.exp_code / 255.0 - 1e-6 &&
                                      dist_a < 10.0 * e.exp_code / 255.0 + 1e-6), 1);
      end else begin
         chk({tag, "_locked"}, int'(lock_b), 1);
         chk({tag, "_busy"}, int'(busy_b), 0);
         chk({tag, "_peak_code"}, int'(pcode_b), e.exp_code);
         chk({tag, "_peak_pwr"}, int'(ppwr_b), e.exp_pwr);
         chk({tag, "_tune"}, int'(tune_b), e.exp_code);
      end
      chk({tag, "_latency"}, lat, e.exp_lat);
      chk({tag, "_no_wrap"}, decr, 0);
      chk({tag, "_last_code"}, mx, 255);
   endtask

   task automatic wait_code(input int code);
      int n;
      n = 0;
      while (int'(tune_a) != code && n < 5000) begin
         tick();
         n++;
      end
      chk("reach_code", int'(tune_a), code);
   endtask

   initial begin
      int lat, decr, mx, gmin, gmax, wmin, wmax;
      vecs[0] = '{0, 0, 100, 100, 900, 256 * 9 + 1};
      vecs[1] = '{0, 0, 17, 17, 900, 256 * 9 + 1};
      vecs[2] = '{0, 1, 0, 40, 700, 256 * 9 + 1};
      vecs[3] = '{1, 0, 255, 255, 900, 86 * 9 + 1};
      vecs[4] = '{1, 0, 100, 99, 800, 86 * 9 + 1};

      rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
      repeat (3) tick();
      chk("rst_tune", int'(tune_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_locked", int'(lock_a), 0);
      chk("rst_peak_code", int'(pcode_a), 0);
      chk("rst_peak_pwr", int'(ppwr_a), 0);
      chk("rst_dist_zero", int'(dist_a == 0.0), 1);
      chk("rst_b_busy", int'(busy_b), 0);
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      tick();
      chk("idle_busy", int'(busy_a), 0);

      foreach (vecs[i]) begin
         mode = vecs[i].md;
         ctr  = vecs[i].c;
         exp_q.push_back(vecs[i]);
         pulse(vecs[i].dut);
         wait_lock(vecs[i].dut, lat, decr, mx);
         check_lock($sformatf("vec%0d", i), lat, decr, mx);
      end

      mode = 0; ctr = 100;
      exp_q.push_back(vecs[0]);
      pulse(0);
      lat = 1;
      while (int'(tune_a) != 20 && lat < 5000) begin
         tick();
         lat++;
      end
      chk("busy_reach20", int'(tune_a), 20);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      lat++;
      chk("busy_ign_tune", int'(tune_a), 20);
      chk("busy_ign_busy", int'(busy_a), 1);
      wait_lock(0, mx, decr, wmax);
      check_lock("busy_ign", lat + mx - 1, decr, 255);

      pulse(0);
      wait_code(60);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_tune", int'(tune_a), 0);
      chk("mrst_busy", int'(busy_a), 0);
      chk("mrst_locked", int'(lock_a), 0);
      chk("mrst_peak_code", int'(pcode_a), 0);
      chk("mrst_peak_pwr", int'(ppwr_a), 0);
      repeat (20) tick();
      chk("mrst_idle_tune", int'(tune_a), 0);
      chk("mrst_idle_busy", int'(busy_a), 0);

      mode = 0; ctr = 100;
      exp_q.push_back(vecs[0]);
      pulse(0);
      wait_lock(0, lat, decr, mx);
      check_lock("trk", lat, decr, mx);
      ctr = 104;
      gmin = 255; gmax = 0; wmin = 255; wmax = 0;
      repeat (400) begin
         if (int'(tune_a) < gmin) gmin = int'(tune_a);
         if (int'(tune_a) > gmax) gmax = int'(tune_a);
         tick();
      end
      repeat (200) begin
         if (int'(tune_a) < wmin) wmin = int'(tune_a);
         if (int'(tune_a) > wmax) wmax = int'(tune_a);
         tick();
      end
      chk("trk_still_locked", int'(lock_a), 1);
`ifdef RING_LOCK_TRACK_EN
      chk("trk_walk_min", gmin, 98);
      chk("trk_walk_max", gmax, 106);
      chk("trk_hold_min", wmin, 102);
      chk("trk_hold_max", wmax, 106);
`else
      chk("trk_walk_min", gmin, 100);
      chk("trk_walk_max", gmax, 100);
      chk("trk_hold_min", wmin, 100);
      chk("trk_hold_max", wmax, 100);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
